// File: rtl/ifid_pipe_ctrl_pkg.sv
// Shared pipeline definitions: opcodes, the bubble instruction and the
// IF/ID controller state encoding.
package pipe_pkg;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_REG    = 7'd51;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        FLUSH    = 2'd2
    } state_e;

    function automatic logic reads_rs1(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM, OP_REG: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        case (op)
            OP_STORE, OP_BRANCH, OP_REG: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ifid_pipe_ctrl_if.sv
// Fetch handshake, IF/ID register view and hazard/redirect signals seen by
// the IF/ID controller.
interface ifid_pipe_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic                if_valid;
    logic [XLEN-1:0]     if_pc;
    logic [XLEN-1:0]     if_instr;
    logic                if_ready;
    logic [2*XLEN-1:0]   ifid_reg;
    logic                ifid_valid;
    logic                idex_memread;
    logic [4:0]          idex_rd;
    logic                ex_branch_taken;
    logic                dmem_busy;
    logic                pc_write;
    logic                idex_bubble;
    logic [CNT_W-1:0]    stall_cnt;

    modport master (
        output if_valid, if_pc, if_instr, idex_memread, idex_rd,
               ex_branch_taken, dmem_busy,
        input  if_ready, ifid_reg, ifid_valid, pc_write, idex_bubble, stall_cnt
    );

    modport slave (
        input  if_valid, if_pc, if_instr, idex_memread, idex_rd,
               ex_branch_taken, dmem_busy,
        output if_ready, ifid_reg, ifid_valid, pc_write, idex_bubble, stall_cnt
    );
endinterface

// File: rtl/ifid_pipe_ctrl_hazard_detect.sv
// Load-use hazard detection between the instruction in IF/ID and a load in EX.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       ifid_valid_i,
    input  logic       idex_memread_i,
    input  logic [4:0] idex_rd_i,
    output logic       hazard_o
);
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = reads_rs1(opcode_i) & (rs1_i == idex_rd_i);
    assign rs2_hit  = reads_rs2(opcode_i) & (rs2_i == idex_rd_i);
    // x0 is never really written, so a load targeting it cannot create a dependency
    assign hazard_o = idex_memread_i & (idex_rd_i != 5'd0) & ifid_valid_i
                    & (rs1_hit | rs2_hit);
endmodule

// File: rtl/ifid_pipe_ctrl.sv
// IF/ID pipeline register with its load/hold/bubble controller, fetch and
// ID/EX stall controls and a saturating stall-cycle counter.
module ifid_pipe_ctrl #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] NOP_INSN     = XLEN'(pipe_pkg::NOP_INSN),
    parameter int              FLUSH_CYCLES = 1,
    parameter int              CNT_W        = 16
) (
    input logic             clk,
    input logic             reset,
    ifid_pipe_ctrl_if.slave bus
);
    import pipe_pkg::*;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_e           state_q;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  instr_q;
    logic             valid_q;
    logic [2:0]       flush_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    logic hazard;
    logic branch;
    logic busy;
    logic ready;

    hazard_detect u_hazard (
        .opcode_i       (instr_q[6:0]),
        .rs1_i          (instr_q[19:15]),
        .rs2_i          (instr_q[24:20]),
        .ifid_valid_i   (valid_q),
        .idex_memread_i (bus.idex_memread),
        .idex_rd_i      (bus.idex_rd),
        .hazard_o       (hazard)
    );

    assign branch = bus.ex_branch_taken;
    assign busy   = bus.dmem_busy;
    assign ready  = (state_q == RUN) & ~branch & ~busy & ~hazard & ~reset;

    assign bus.if_ready    = ready;
    assign bus.pc_write    = ready | branch;
    // ID/EX is frozen while memory is busy, so only a redirect forces a bubble then
    assign bus.idex_bubble = branch | (~busy & (hazard | (state_q == FLUSH)));
    assign bus.ifid_reg    = {pc_q, instr_q};
    assign bus.ifid_valid  = valid_q;
    assign bus.stall_cnt   = stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (((state_q != RUN) | hazard | busy) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            pc_q        <= '0;
            instr_q     <= NOP_INSN;
            valid_q     <= 1'b0;
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            // A taken branch squashes IF/ID from any state
            if (branch) begin
                instr_q     <= NOP_INSN;
                valid_q     <= 1'b0;
                flush_cnt_q <= FLUSH_INIT;
                state_q     <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            end else begin
                case (state_q)
                    FLUSH: begin
                        if (flush_cnt_q <= 3'd1) begin
                            flush_cnt_q <= '0;
                            state_q     <= RUN;
                        end else begin
                            flush_cnt_q <= flush_cnt_q - 3'd1;
                        end
                    end
                    WAIT_MEM: begin
                        if (!busy) begin
                            state_q <= RUN;
                        end
                    end
                    default: begin
                        if (busy) begin
                            state_q <= WAIT_MEM;
                        end else if (!hazard) begin
                            if (bus.if_valid) begin
                                pc_q    <= bus.if_pc;
                                instr_q <= bus.if_instr;
                                valid_q <= 1'b1;
                            end else begin
                                instr_q <= NOP_INSN;
                                valid_q <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ifid_pipe_ctrl.sv
// Bench for ifid_pipe_ctrl: directed scenarios plus random traffic, checked
// every cycle against a behavioural model of the IF/ID controller.
module tb_ifid_pipe_ctrl;
    localparam int          XLEN = 32;
    localparam int          FC   = 2;
    localparam int          CW   = 4;
    localparam int          SAT  = (1 << CW) - 1;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ifid_pipe_ctrl_if #(.XLEN(XLEN), .CNT_W(CW)) bus ();

    ifid_pipe_ctrl #(
        .XLEN(XLEN), .NOP_INSN(NOP), .FLUSH_CYCLES(FC), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] m_pc, m_instr;
    bit          m_valid, m_wait;
    int          m_flush, m_stall;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic bit m_hazard();
        logic [6:0] op;
        bit u1, u2;
        op = m_instr[6:0];
        u1 = (op == 7'd3) || (op == 7'd35) || (op == 7'd99) || (op == 7'd19) || (op == 7'd51);
        u2 = (op == 7'd35) || (op == 7'd99) || (op == 7'd51);
        return bus.idex_memread && (bus.idex_rd != 5'd0) && m_valid &&
               ((u1 && (m_instr[19:15] == bus.idex_rd)) || (u2 && (m_instr[24:20] == bus.idex_rd)));
    endfunction

    function automatic bit m_running();
        return !m_wait && (m_flush == 0);
    endfunction

    task automatic compare_all();
        bit hz, rdy, br, busy;
        hz   = m_hazard();
        br   = bus.ex_branch_taken;
        busy = bus.dmem_busy;
        rdy  = m_running() && !br && !busy && !hz && !reset;
        chk("if_ready",    64'(bus.if_ready),    64'(rdy));
        chk("pc_write",    64'(bus.pc_write),    64'(rdy || br));
        chk("idex_bubble", 64'(bus.idex_bubble), 64'(br || (!busy && (hz || m_flush > 0))));
        chk("ifid_reg",    bus.ifid_reg,         {m_pc, m_instr});
        chk("ifid_valid",  64'(bus.ifid_valid),  64'(m_valid));
        chk("stall_cnt",   64'(bus.stall_cnt),   64'(m_stall));
    endtask

    task automatic model_update();
        bit hz;
        if (reset) begin
            m_pc = '0; m_instr = NOP; m_valid = 0; m_wait = 0; m_flush = 0; m_stall = 0;
        end else begin
            hz = m_hazard();
            if (!m_running() || hz || bus.dmem_busy) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
            if (bus.ex_branch_taken) begin
                m_instr = NOP; m_valid = 0; m_wait = 0; m_flush = FC - 1;
            end else if (m_flush > 0) begin
                m_flush--;
            end else if (bus.dmem_busy) begin
                m_wait = 1;
            end else if (m_wait) begin
                m_wait = 0;
            end else if (!hz) begin
                if (bus.if_valid) begin
                    m_pc = bus.if_pc; m_instr = bus.if_instr; m_valid = 1;
                end else begin
                    m_instr = NOP; m_valid = 0;
                end
            end
        end
    endtask

    // Inputs change at the falling edge; outputs are compared just after it
    task automatic step();
        #1;
        compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  op;
        case ($urandom_range(0, 6))
            0: op = 7'd3;
            1: op = 7'd35;
            2: op = 7'd99;
            3: op = 7'd19;
            4: op = 7'd51;
            5: op = 7'd55;
            default: op = 7'd111;
        endcase
        w        = $urandom;
        w[6:0]   = op;
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    initial begin
        bus.if_valid = 0; bus.if_pc = '0; bus.if_instr = '0;
        bus.idex_memread = 0; bus.idex_rd = '0;
        bus.ex_branch_taken = 0; bus.dmem_busy = 0;
        reset = 1;
        @(posedge clk);
        model_update();
        @(negedge clk);
        reset = 0;
        #1;
        chk("reset_ifid_reg", bus.ifid_reg, 64'h00000000_00000013);
        chk("reset_valid", 64'(bus.ifid_valid), 64'd0);
        chk("reset_stall", 64'(bus.stall_cnt), 64'd0);

        // Normal flow
        bus.if_valid = 1; bus.if_pc = 32'h100; bus.if_instr = 32'h00A00093;
        #1 chk("normal_ready", 64'(bus.if_ready), 64'd1);
        step();
        chk("normal_ifid", bus.ifid_reg, 64'h00000100_00A00093);
        chk("normal_valid", 64'(bus.ifid_valid), 64'd1);

        // Load-use on add x3,x1,x2
        bus.if_pc = 32'h104; bus.if_instr = 32'h002081B3;
        step();
        bus.idex_memread = 1; bus.idex_rd = 5'd2;
        bus.if_pc = 32'h108; bus.if_instr = 32'h0020A023;
        #1;
        chk("lu_ready", 64'(bus.if_ready), 64'd0);
        chk("lu_pc_write", 64'(bus.pc_write), 64'd0);
        chk("lu_bubble", 64'(bus.idex_bubble), 64'd1);
        step();
        chk("lu_hold", bus.ifid_reg, 64'h00000104_002081B3);
        chk("lu_stall", 64'(bus.stall_cnt), 64'd1);

        // Load to x0 never stalls; store with rs2 match does
        bus.idex_rd = 5'd0;
        #1 chk("rd0_ready", 64'(bus.if_ready), 64'd1);
        step();
        chk("store_ifid", bus.ifid_reg, 64'h00000108_0020A023);
        bus.idex_rd = 5'd2; bus.if_pc = 32'h10C; bus.if_instr = 32'h00100113;
        #1 chk("store_rs2_ready", 64'(bus.if_ready), 64'd0);
        step();
        bus.idex_memread = 0; bus.idex_rd = 5'd0;
        chk("store_stall", 64'(bus.stall_cnt), 64'd2);
        step();

        // Branch flush, two bubble cycles
        bus.ex_branch_taken = 1; bus.if_pc = 32'h110; bus.if_instr = 32'h00200193;
        #1;
        chk("br_pc_write", 64'(bus.pc_write), 64'd1);
        chk("br_ready", 64'(bus.if_ready), 64'd0);
        step();
        bus.ex_branch_taken = 0; bus.if_pc = 32'h200; bus.if_instr = 32'h00300213;
        chk("br_nop1", 64'(bus.ifid_reg[31:0]), 64'h13);
        chk("br_valid1", 64'(bus.ifid_valid), 64'd0);
        step();
        chk("br_valid2", 64'(bus.ifid_valid), 64'd0);
        step();
        chk("br_resume", bus.ifid_reg, 64'h00000200_00300213);

        // Memory wait
        reset = 1;
        step();
        reset = 0;
        chk("rst2_stall", 64'(bus.stall_cnt), 64'd0);
        step();
        bus.dmem_busy = 1; bus.if_pc = 32'h300; bus.if_instr = 32'h00400293;
        repeat (3) step();
        bus.dmem_busy = 0;
        #1;
        chk("mem_stall", 64'(bus.stall_cnt), 64'd3);
        chk("mem_ready", 64'(bus.if_ready), 64'd0);
        chk("mem_hold", bus.ifid_reg, 64'h00000200_00300213);
        step();
        chk("mem_exit_hold", bus.ifid_reg, 64'h00000200_00300213);
        #1 chk("mem_exit_ready", 64'(bus.if_ready), 64'd1);
        step();
        chk("mem_load", bus.ifid_reg, 64'h00000300_00400293);

        // Reset mid-flush, then counter saturation
        bus.ex_branch_taken = 1;
        step();
        bus.ex_branch_taken = 0; reset = 1;
        step();
        reset = 0;
        chk("rstf_valid", 64'(bus.ifid_valid), 64'd0);
        chk("rstf_stall", 64'(bus.stall_cnt), 64'd0);
        #1 chk("rstf_ready", 64'(bus.if_ready), 64'd1);
        bus.dmem_busy = 1;
        repeat (20) step();
        chk("sat_stall", 64'(bus.stall_cnt), 64'd15);
        bus.dmem_busy = 0;
        step();
        chk("sat_hold", 64'(bus.stall_cnt), 64'd15);

        // Random traffic
        repeat (800) begin
            reset               = ($urandom_range(0, 49) == 0);
            bus.ex_branch_taken = ($urandom_range(0, 7) == 0);
            bus.dmem_busy       = ($urandom_range(0, 5) == 0);
            bus.idex_memread    = ($urandom_range(0, 2) == 0);
            bus.idex_rd         = 5'($urandom_range(0, 7));
            bus.if_valid        = ($urandom_range(0, 3) != 0);
            bus.if_pc           = $urandom;
            bus.if_instr        = rand_instr();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
